// File: rtl/cnn_pkg.sv
// Shared CNN layer definitions: layer FSM state encoding and flat feature-map indexing.
// Used by the forward and backward activation layers.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } layer_state_t;

    // Flat element index of (ch,row,col) in a channel-major, row-major map.
    function automatic int unsigned idx3(input int unsigned ch, input int unsigned row,
                                         input int unsigned col, input int unsigned height,
                                         input int unsigned width);
        return (ch * height + row) * width + col;
    endfunction

endpackage

// File: rtl/relu_backward_gate.sv
// Combinational ReLU gradient gate for one element. Macro RELU_BWD_LEAKY_EN selects the
// leaky variant (negative side scaled by 2^-LEAK_SHIFT) instead of zeroing.
module relu_grad_gate #(
    parameter int DATA_WIDTH = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                  i_fwd_sign,
    input  logic [DATA_WIDTH-1:0] i_grad,
    output logic [DATA_WIDTH-1:0] o_grad,
    output logic                  o_mask
);

`ifdef RELU_BWD_LEAKY_EN
    localparam bit LEAKY_EN = 1'b1;
`else
    localparam bit LEAKY_EN = 1'b0;
`endif

    if (LEAK_SHIFT >= DATA_WIDTH) begin : g_bad_shift
        $error("relu_grad_gate: LEAK_SHIFT must be smaller than DATA_WIDTH");
    end

    logic signed [DATA_WIDTH-1:0] w_leak;

    // A zero forward input passes, matching the forward ReLU which outputs 0 for it.
    assign o_mask = ~i_fwd_sign;
    assign w_leak = $signed(i_grad) >>> LEAK_SHIFT;
    assign o_grad = o_mask ? i_grad : (LEAKY_EN ? w_leak : '0);

endmodule

// File: rtl/relu_backward.sv
// ReLU backward pass: walks the CHANNELS x IMG_SIZE x IMG_SIZE map once per start, one
// element per cycle, and counts pass-through elements. Optional macro RELU_BWD_LEAKY_EN.
module relu_backward
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 7,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28,
    parameter int LEAK_SHIFT = 3,
    localparam int N         = CHANNELS * IMG_SIZE * IMG_SIZE,
    localparam int CNT_W     = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH*N-1:0] fwd_in_flat,
    input  logic [DATA_WIDTH*N-1:0] grad_in_flat,
    output logic [DATA_WIDTH*N-1:0] grad_out_flat,
    output logic                    busy,
    output logic [CNT_W-1:0]        active_count,
    output logic                    done
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(IMG_SIZE - 1);

    if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
        $error("relu_backward: FRAC_BITS must be smaller than DATA_WIDTH");
    end

    layer_state_t            r_state;
    layer_state_t            w_next_state;
    logic [CW-1:0]           r_c;
    logic [PW-1:0]           r_r;
    logic [PW-1:0]           r_q;
    logic [CNT_W-1:0]        r_active_count;
    logic                    r_done;
    logic [DATA_WIDTH*N-1:0] r_grad_out;
    logic [31:0]             w_idx;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_mask;
    logic [DATA_WIDTH-1:0]   w_gate_out;

    assign w_idx  = idx3(32'(r_c), 32'(r_r), 32'(r_q), IMG_SIZE, IMG_SIZE);
    assign w_last = (r_c == C_LAST) && (r_r == P_LAST) && (r_q == P_LAST);

    relu_grad_gate #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_gate (
        .i_fwd_sign (fwd_in_flat[w_idx*DATA_WIDTH + DATA_WIDTH - 1]),
        .i_grad     (grad_in_flat[w_idx*DATA_WIDTH +: DATA_WIDTH]),
        .o_grad     (w_gate_out),
        .o_mask     (w_mask)
    );

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN:     if (w_last) w_next_state = FINISH;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_c            <= '0;
            r_r            <= '0;
            r_q            <= '0;
            r_active_count <= '0;
            r_done         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == FINISH);
            if (w_accept) begin
                r_c            <= '0;
                r_r            <= '0;
                r_q            <= '0;
                r_active_count <= '0;
            end else if (r_state == RUN) begin
                if (w_mask) r_active_count <= r_active_count + 1'b1;
                // Column fastest, then row, then channel; all wrap to 0 after the last element.
                if (r_q == P_LAST) begin
                    r_q <= '0;
                    if (r_r == P_LAST) begin
                        r_r <= '0;
                        r_c <= (r_c == C_LAST) ? '0 : r_c + 1'b1;
                    end else begin
                        r_r <= r_r + 1'b1;
                    end
                end else begin
                    r_q <= r_q + 1'b1;
                end
            end
        end
    end

    // Output map is plain storage: never cleared, written only while a pass runs.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == RUN)) begin
            r_grad_out[w_idx*DATA_WIDTH +: DATA_WIDTH] <= w_gate_out;
        end
    end

    assign busy          = (r_state == RUN) || (r_state == FINISH);
    assign done          = r_done;
    assign active_count  = r_active_count;
    assign grad_out_flat = r_grad_out;

endmodule

// File: tb/tb_relu_backward.sv
// Testbench for relu_backward: a tiny 1x2x2 instance for timing/control cases and a
// default-size instance for full-map passes, both checked against a reference model.
module tb_relu_backward;

    localparam int DW    = 16;
    localparam int SN    = 4;
    localparam int BN    = 8 * 28 * 28;
    localparam int SCW   = $clog2(SN + 1);
    localparam int BCW   = $clog2(BN + 1);
    localparam int SHIFT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic start_s = 1'b0;
    logic start_b = 1'b0;

    logic [SN*DW-1:0] fwd_s  = '0;
    logic [SN*DW-1:0] grad_s = '0;
    logic [SN*DW-1:0] gout_s;
    logic [SN*DW-1:0] old_out;
    logic             busy_s, done_s;
    logic [SCW-1:0]   cnt_s;

    logic [BN*DW-1:0] fwd_b  = '0;
    logic [BN*DW-1:0] grad_b = '0;
    logic [BN*DW-1:0] gout_b;
    logic             busy_b, done_b;
    logic [BCW-1:0]   cnt_b;

    relu_backward #(
        .DATA_WIDTH (DW), .FRAC_BITS (7), .CHANNELS (1), .IMG_SIZE (2), .LEAK_SHIFT (SHIFT)
    ) u_small (
        .clk (clk), .reset (reset), .start (start_s),
        .fwd_in_flat (fwd_s), .grad_in_flat (grad_s), .grad_out_flat (gout_s),
        .busy (busy_s), .active_count (cnt_s), .done (done_s)
    );

    relu_backward u_big (
        .clk (clk), .reset (reset), .start (start_b),
        .fwd_in_flat (fwd_b), .grad_in_flat (grad_b), .grad_out_flat (gout_b),
        .busy (busy_b), .active_count (cnt_b), .done (done_b)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference gradient: pass when forward input is non-negative, otherwise zero
    // (or floor(grad / 2^SHIFT) in the leaky build).
    function automatic logic [DW-1:0] model(input int f, input int g);
        int q;
        if (f >= 0) return DW'(g);
`ifdef RELU_BWD_LEAKY_EN
        q = g / (1 << SHIFT);
        if (g < 0 && (g % (1 << SHIFT)) != 0) q = q - 1;
        return DW'(q);
`else
        q = 0;
        return DW'(q);
`endif
    endfunction

    function automatic int elem(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a small pass at edge 0; optionally raise start again at edge repulse_at.
    // Reports the first edge after which done is visible and the number of done pulses.
    task automatic small_pass(input int repulse_at, output int first_done, output int pulses);
        start_s = 1'b1;
        tick();
        first_done = -1;
        pulses     = 0;
        for (int k = 1; k <= SN + 8; k++) begin
            start_s = (k == repulse_at);
            tick();
            if (done_s === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = k;
            end
        end
        start_s = 1'b0;
    endtask

    task automatic check_small(input string tag);
        int exp_cnt;
        exp_cnt = 0;
        for (int i = 0; i < SN; i++) begin
            if (elem(fwd_s[i*DW +: DW]) >= 0) exp_cnt++;
            check($sformatf("%s_elem%0d", tag, i), {16'b0, gout_s[i*DW +: DW]},
                  {16'b0, model(elem(fwd_s[i*DW +: DW]), elem(grad_s[i*DW +: DW]))});
        end
        check($sformatf("%s_count", tag), 32'(cnt_s), 32'(exp_cnt));
    endtask

    task automatic big_pass(input string tag);
        int first_done, bad, exp_cnt;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        first_done = -1;
        for (int k = 1; k <= BN + 10 && first_done < 0; k++) begin
            tick();
            if (done_b === 1'b1) first_done = k;
        end
        check($sformatf("%s_done_edge", tag), 32'(first_done), 32'(BN + 1));
        bad = 0;
        exp_cnt = 0;
        for (int i = 0; i < BN; i++) begin
            if (elem(fwd_b[i*DW +: DW]) >= 0) exp_cnt++;
            if (gout_b[i*DW +: DW] !== model(elem(fwd_b[i*DW +: DW]), elem(grad_b[i*DW +: DW])))
                bad++;
        end
        check($sformatf("%s_bad_elems", tag), 32'(bad), 32'd0);
        check($sformatf("%s_count", tag), 32'(cnt_b), 32'(exp_cnt));
    endtask

    function automatic logic [DW-1:0] rand_fwd();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return DW'($urandom_range(1, 32767));
            default: return DW'($urandom);
        endcase
    endfunction

    // ---------------- directed sequence ----------------
    int df[SN] = '{5, -3, 0, -1};
`ifdef RELU_BWD_LEAKY_EN
    int dg[SN] = '{10, -16, 30, 40};
    int de[SN] = '{10, -2, 30, 5};
`else
    int dg[SN] = '{10, 20, 30, -40};
    int de[SN] = '{10, 0, 30, 0};
`endif

    initial begin
        int fd, np;

        // Reset, then idle.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("idle_done", {31'b0, done_s}, 32'd0);
        check("idle_busy", {31'b0, busy_s}, 32'd0);
        check("idle_count", 32'(cnt_s), 32'd0);
        check("idle_big_count", 32'(cnt_b), 32'd0);
        check("idle_big_busy", {31'b0, busy_b}, 32'd0);

        // Directed pass with known values; done becomes visible after edge N+1 and is
        // therefore sampled high at edge N+2.
        for (int i = 0; i < SN; i++) begin
            fwd_s[i*DW +: DW]  = DW'(df[i]);
            grad_s[i*DW +: DW] = DW'(dg[i]);
        end
        small_pass(0, fd, np);
        check("dir_done_edge", 32'(fd), 32'(SN + 1));
        check("dir_done_pulses", 32'(np), 32'd1);
        for (int i = 0; i < SN; i++)
            check($sformatf("dir_elem%0d", i), {16'b0, gout_s[i*DW +: DW]}, {16'b0, DW'(de[i])});
        check("dir_count", 32'(cnt_s), 32'd2);
        check("dir_idle_busy", {31'b0, busy_s}, 32'd0);

        // Start pulsed again mid-pass is ignored.
        small_pass(2, fd, np);
        check("repulse_done_edge", 32'(fd), 32'(SN + 1));
        check("repulse_done_pulses", 32'(np), 32'd1);
        check_small("repulse");

        // Reset after two elements: abort, no done, written elements keep new values.
        old_out = gout_s;
        for (int i = 0; i < SN; i++) begin
            fwd_s[i*DW +: DW]  = rand_fwd();
            grad_s[i*DW +: DW] = DW'($urandom);
        end
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        tick();
        check("mid_busy", {31'b0, busy_s}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("rst_busy", {31'b0, busy_s}, 32'd0);
        check("rst_count", 32'(cnt_s), 32'd0);
        reset = 1'b0;
        np = 0;
        for (int k = 0; k < 10; k++) begin
            if (done_s === 1'b1) np++;
            tick();
        end
        check("rst_no_done", 32'(np), 32'd0);
        for (int i = 0; i < 2; i++)
            check($sformatf("rst_written%0d", i), {16'b0, gout_s[i*DW +: DW]},
                  {16'b0, model(elem(fwd_s[i*DW +: DW]), elem(grad_s[i*DW +: DW]))});
        for (int i = 2; i < SN; i++)
            check($sformatf("rst_kept%0d", i), {16'b0, gout_s[i*DW +: DW]},
                  {16'b0, old_out[i*DW +: DW]});
        small_pass(0, fd, np);
        check("restart_done_edge", 32'(fd), 32'(SN + 1));
        check_small("restart");

        // Start held high: back-to-back passes, one every N+2 cycles.
        exp_q.push_back(32'(SN + 1));
        exp_q.push_back(32'(2 * SN + 3));
        start_s = 1'b1;
        tick();
        np = 0;
        for (int k = 1; k <= 2 * SN + 4; k++) begin
            tick();
            if (done_s === 1'b1) begin
                np++;
                if (exp_q.size() > 0) check("b2b_done_edge", 32'(k), exp_q.pop_front());
                else check("b2b_extra_done", 32'(k), 32'd0);
            end
        end
        start_s = 1'b0;
        check("b2b_pulses", 32'(np), 32'd2);
        check("b2b_missing", 32'(exp_q.size()), 32'd0);
        repeat (SN + 4) tick();
        check_small("b2b");

        // Randomized small passes.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < SN; i++) begin
                fwd_s[i*DW +: DW]  = rand_fwd();
                grad_s[i*DW +: DW] = DW'($urandom);
            end
            small_pass(0, fd, np);
            check($sformatf("rnd%0d_done_edge", n), 32'(fd), 32'(SN + 1));
            check_small($sformatf("rnd%0d", n));
        end

        // Full-size map: all negative, all zero, then random.
        for (int i = 0; i < BN; i++) begin
            fwd_b[i*DW +: DW]  = '1;
            grad_b[i*DW +: DW] = DW'($urandom);
        end
        big_pass("big_neg");
        for (int i = 0; i < BN; i++) fwd_b[i*DW +: DW] = '0;
        big_pass("big_zero");
        check("big_zero_full", 32'(cnt_b), 32'(BN));
        for (int i = 0; i < BN; i++) begin
            fwd_b[i*DW +: DW]  = rand_fwd();
            grad_b[i*DW +: DW] = DW'($urandom);
        end
        big_pass("big_rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
